// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed 4-digit 7-segment scanner.
// The display value is double-buffered. A load captures data_in as the
// pending value. The pending value is committed to the displayed register
// only when the scan wraps from digit 3 back to digit 0, so a frame never
// shows a mix of old and new digits.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   data_in     16-bit value to show; nibble 0 is the rightmost digit
//   load        one-cycle strobe that captures data_in as the pending value
//   lz_en       leading-zero suppression enable, sampled on slot ticks
//   dp_in       per-digit decimal point, active-high, sampled on slot ticks
//   bcd         nibble of the current digit, to the hex decoder
//   an          active-low common-anode enables; an[0] is the rightmost digit
//   dp          decimal point, active-low
//   frame_start one-cycle pulse in the first cycle of each digit-0 slot
module seg_scan #(
    parameter int unsigned CLK_DIV = 50000,
    parameter int unsigned DEAD    = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_in,
    input  logic        load,
    input  logic        lz_en,
    input  logic [3:0]  dp_in,
    output logic [3:0]  bcd,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame_start
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] dcnt;
    logic [1:0]       idx;
    logic [15:0]      disp;
    logic [15:0]      pending;
    logic             pend_vld;
    logic             blank;

    logic             tick;
    logic             wrap;
    logic [1:0]       idx_n;
    logic [15:0]      disp_n;
    logic [CNT_W-1:0] dcnt_n;
    logic             blank_n;
    logic [3:0]       bcd_n;
    logic [3:0]       an_n;
    logic             dp_n;

    // Outputs are registered, so each one is derived from the value its
    // source state takes on the same edge. This keeps an, bcd and dp
    // aligned with idx/dcnt rather than lagging them by one cycle.
    always_comb begin
        tick    = (cnt == CNT_W'(CLK_DIV - 1));
        wrap    = tick && (idx == 2'd3);
        idx_n   = tick ? idx + 2'd1 : idx;
        disp_n  = (wrap && pend_vld) ? pending : disp;
        dcnt_n  = '0;
        if (tick) begin
            dcnt_n = CNT_W'(DEAD);
        end else if (dcnt != '0) begin
            dcnt_n = dcnt - CNT_W'(1);
        end

        // A digit is blanked when it and all higher digits are zero.
        // Digit 0 is never blanked.
        blank_n = blank;
        if (tick) begin
            case (idx_n)
                2'd1:    blank_n = lz_en && (disp_n[15:4]  == '0);
                2'd2:    blank_n = lz_en && (disp_n[15:8]  == '0);
                2'd3:    blank_n = lz_en && (disp_n[15:12] == '0);
                default: blank_n = 1'b0;
            endcase
        end

        bcd_n = tick ? disp_n[{idx_n, 2'b00} +: 4] : bcd;
        dp_n  = dp;
        if (tick) begin
            dp_n = blank_n ? 1'b1 : ~dp_in[idx_n];
        end
        an_n = ((dcnt_n != '0) || blank_n) ? 4'b1111 : ~(4'b0001 << idx_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            dcnt        <= CNT_W'(DEAD);
            idx         <= '0;
            disp        <= '0;
            pending     <= '0;
            pend_vld    <= 1'b0;
            blank       <= 1'b0;
            bcd         <= '0;
            an          <= '1;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            cnt         <= tick ? '0 : cnt + CNT_W'(1);
            dcnt        <= dcnt_n;
            idx         <= idx_n;
            disp        <= disp_n;
            blank       <= blank_n;
            bcd         <= bcd_n;
            an          <= an_n;
            dp          <= dp_n;
            frame_start <= wrap;
            if (wrap && pend_vld) begin
                pend_vld <= 1'b0;
            end
            // A load on the commit edge wins over the clear above. The
            // commit has already taken the old pending value through
            // disp_n, so the new value waits for the next frame.
            if (load) begin
                pending  <= data_in;
                pend_vld <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
module tb_seg_scan;

    localparam int unsigned CLK_DIV = 8;
    localparam int unsigned DEAD    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data_in;
    logic        load;
    logic        lz_en;
    logic [3:0]  dp_in;
    logic [3:0]  bcd;
    logic [3:0]  an;
    logic        dp;
    logic        frame_start;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] bcd;
        logic [3:0] an;
        logic       dp;
    } exp_t;

    exp_t q[$];

    seg_scan #(.CLK_DIV(CLK_DIV), .DEAD(DEAD), .CNT_W(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .data_in(data_in),
        .load(load),
        .lz_en(lz_en),
        .dp_in(dp_in),
        .bcd(bcd),
        .an(an),
        .dp(dp),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Expected per-digit outputs for one frame, derived from the value shown.
    task automatic expect_frame(input logic [15:0] val, input logic lz, input logic [3:0] dpi);
        exp_t e;
        logic [15:0] hi;
        logic blk;
        for (int d = 0; d < 4; d++) begin
            hi    = val >> (4 * d);
            blk   = lz && (d > 0) && (hi == 16'h0);
            e.bcd = hi[3:0];
            e.an  = blk ? 4'b1111 : ~(4'b0001 << d);
            e.dp  = blk ? 1'b1 : ~dpi[d];
            q.push_back(e);
        end
    endtask

    // Waits for frame_start, then checks one whole frame against the queue.
    // Ends on the negedge of the last cycle of the frame.
    task automatic check_frame();
        int n;
        exp_t e;
        n = 0;
        while (!frame_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!frame_start) begin
            errors++;
            checks++;
            $error("FAIL frame_start_timeout: observed=0 expected=1");
            q.delete();
            return;
        end
        for (int d = 0; d < 4; d++) begin
            e = q.pop_front();
            for (int o = 0; o < CLK_DIV; o++) begin
                if (o == 0 || o == 1) begin
                    chk($sformatf("an_dead_d%0d_o%0d", d, o), {12'h0, an}, 16'h000F);
                end
                if (o == 2 || o == CLK_DIV - 1) begin
                    chk($sformatf("an_lit_d%0d_o%0d", d, o), {12'h0, an}, {12'h0, e.an});
                end
                if (o == 0 || o == 1 || o == 2 || o == CLK_DIV - 1) begin
                    chk($sformatf("bcd_d%0d_o%0d", d, o), {12'h0, bcd}, {12'h0, e.bcd});
                    chk($sformatf("dp_d%0d_o%0d", d, o), {15'h0, dp}, {15'h0, e.dp});
                    chk($sformatf("fs_d%0d_o%0d", d, o), {15'h0, frame_start},
                        {15'h0, (d == 0 && o == 0)});
                end
                if (!(d == 3 && o == CLK_DIV - 1)) begin
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic skip(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        data_in = v;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
    endtask

    task automatic check_restart();
        @(negedge clk);
        chk("restart_an_dead", {12'h0, an}, 16'h000F);
        chk("restart_fs", {15'h0, frame_start}, 16'h0000);
        @(negedge clk);
        chk("restart_an_lit", {12'h0, an}, 16'h000E);
        chk("restart_bcd", {12'h0, bcd}, 16'h0000);
        chk("restart_dp", {15'h0, dp}, 16'h0001);
    endtask

    initial begin
        rst_n   = 1'b0;
        data_in = '0;
        load    = 1'b0;
        lz_en   = 1'b0;
        dp_in   = '0;
        skip(3);
        chk("rst_an", {12'h0, an}, 16'h000F);
        chk("rst_bcd", {12'h0, bcd}, 16'h0000);
        chk("rst_dp", {15'h0, dp}, 16'h0001);
        chk("rst_fs", {15'h0, frame_start}, 16'h0000);
        rst_n = 1'b1;
        check_restart();
        expect_frame(16'h0000, 1'b0, 4'h0);
        check_frame();

        // Load mid-frame: the current frame keeps showing the old value.
        skip(10);
        do_load(16'h12AF);
        chk("hold_before_commit", {12'h0, bcd}, 16'h0000);
        expect_frame(16'h12AF, 1'b0, 4'h0);
        check_frame();

        // Leading-zero suppression.
        skip(10);
        lz_en = 1'b1;
        do_load(16'h0005);
        expect_frame(16'h0005, 1'b1, 4'h0);
        check_frame();
        skip(10);
        do_load(16'h0100);
        expect_frame(16'h0100, 1'b1, 4'h0);
        check_frame();

        // Two loads in one frame: last value wins.
        skip(10);
        lz_en = 1'b0;
        do_load(16'h1111);
        skip(2);
        do_load(16'h2222);
        expect_frame(16'h2222, 1'b0, 4'h0);
        check_frame();

        // Load on the commit edge: commit takes the prior pending value.
        skip(10);
        do_load(16'h3333);
        skip(CLK_DIV * 4 - 11);
        do_load(16'h5555);
        expect_frame(16'h3333, 1'b0, 4'h0);
        check_frame();
        expect_frame(16'h5555, 1'b0, 4'h0);
        check_frame();

        // Decimal point on digit 2 only, sampled from the wrap edge onward.
        dp_in = 4'b0100;
        expect_frame(16'h5555, 1'b0, 4'b0100);
        check_frame();
        dp_in = 4'b0000;

        // Reset in the middle of digit 2 with a pending value outstanding.
        skip(10);
        do_load(16'h7777);
        skip(10);
        chk("pre_reset_bcd", {12'h0, bcd}, 16'h0005);
        rst_n = 1'b0;
        #1;
        chk("async_rst_an", {12'h0, an}, 16'h000F);
        chk("async_rst_bcd", {12'h0, bcd}, 16'h0000);
        chk("async_rst_dp", {15'h0, dp}, 16'h0001);
        skip(2);
        rst_n = 1'b1;
        check_restart();
        expect_frame(16'h0000, 1'b0, 4'h0);
        check_frame();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule
